issue_queue: RTL



---
 rtl/issue_queue_if.sv | 41 ++++
 rtl/issue_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// Bundles the issue queue's op-insert, wakeup, issue and status signals.
// master: the surrounding pipeline (register-read, execute/writeback, execute).
// slave : the issue queue itself.
interface issue_queue_if #(
    parameter int DEPTH            = 8,
    parameter int READREG_WIDTH    = 2,
    parameter int WAKEUP_NUM       = 4,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int PAYLOAD_WIDTH    = 128
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic [READREG_WIDTH-1:0]                             in_valid;
    logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]          in_payload;
    logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]  in_src_phy;
    logic [READREG_WIDTH-1:0][1:0]                        in_src_loaded;
    logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]    in_src_value;
    logic                                                 stall;
    logic                                                 flush;
    logic [WAKEUP_NUM-1:0]                                wakeup_enable;
    logic [WAKEUP_NUM-1:0][PHY_REG_ID_WIDTH-1:0]          wakeup_phy_id;
    logic [WAKEUP_NUM-1:0][REG_DATA_WIDTH-1:0]            wakeup_value;
    logic                                                 issue_valid;
    logic                                                 issue_ready;
    logic [PAYLOAD_WIDTH-1:0]                             issue_payload;
    logic [1:0][REG_DATA_WIDTH-1:0]                       issue_src_value;
    logic [CW-1:0]                                        count;

    modport master (
        output in_valid, in_payload, in_src_phy, in_src_loaded, in_src_value,
        output flush, wakeup_enable, wakeup_phy_id, wakeup_value, issue_ready,
        input  stall, issue_valid, issue_payload, issue_src_value, count
    );

    modport slave (
        input  in_valid, in_payload, in_src_phy, in_src_loaded, in_src_value,
        input  flush, wakeup_enable, wakeup_phy_id, wakeup_value, issue_ready,
        output stall, issue_valid, issue_payload, issue_src_value, count
    );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: compacted age-ordered buffer (index 0 = oldest),
// captures missing operands from wakeup broadcasts and issues the oldest
// ready op, one per cycle.
// Optional feature macro: ISSUE_QUEUE_INSERT_WAKEUP_EN -- incoming ops also
// snoop the same-cycle wakeup channels so a result broadcast in the insert
// cycle is not missed.
// Occupancy is implied by count_q: entry i is valid iff i < count_q.
module issue_queue #(
    parameter int DEPTH            = 8,
    parameter int READREG_WIDTH    = 2,
    parameter int WAKEUP_NUM       = 4,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int PAYLOAD_WIDTH    = 128
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave iq
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PAYLOAD_WIDTH-1:0]              payload_q [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]              payload_d [DEPTH];
    logic [1:0][PHY_REG_ID_WIDTH-1:0]      phy_q     [DEPTH];
    logic [1:0][PHY_REG_ID_WIDTH-1:0]      phy_d     [DEPTH];
    logic [1:0]                            loaded_q  [DEPTH];
    logic [1:0]                            loaded_d  [DEPTH];
    logic [1:0][REG_DATA_WIDTH-1:0]        value_q   [DEPTH];
    logic [1:0][REG_DATA_WIDTH-1:0]        value_d   [DEPTH];
    logic [CW-1:0]                         count_q, count_d;

    logic [1:0]                            wk_loaded [DEPTH];
    logic [1:0][REG_DATA_WIDTH-1:0]        wk_value  [DEPTH];
    logic                                  sel_found;
    logic [IW-1:0]                         sel_idx;
    logic                                  do_issue;
    logic                                  accept;

    // Stored entries with this cycle's wakeup broadcasts applied; lowest channel wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                wk_loaded[i][s] = loaded_q[i][s];
                wk_value[i][s]  = value_q[i][s];
                if (!loaded_q[i][s]) begin
                    for (int c = WAKEUP_NUM - 1; c >= 0; c--) begin
                        if (iq.wakeup_enable[c] && iq.wakeup_phy_id[c] == phy_q[i][s]) begin
                            wk_loaded[i][s] = 1'b1;
                            wk_value[i][s]  = iq.wakeup_value[c];
                        end
                    end
                end
            end
        end
    end

    // Oldest entry whose registered operands are both present.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < int'(count_q) && (&loaded_q[i])) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign iq.issue_valid     = sel_found && !iq.flush;
    assign iq.issue_payload   = payload_q[sel_idx];
    assign iq.issue_src_value = value_q[sel_idx];
    assign iq.stall           = (count_q > CW'(DEPTH - READREG_WIDTH));
    assign iq.count           = count_q;
    assign do_issue           = iq.issue_valid && iq.issue_ready;
    assign accept             = !iq.stall && !iq.flush;

    // Next entry contents: close the gap left by an issued op, then append inserts.
    always_comb begin
        int base;
        int pos;
        int idx;
        logic [1:0]                     nl;
        logic [1:0][REG_DATA_WIDTH-1:0] nv;
        for (int i = 0; i < DEPTH; i++) begin
            payload_d[i] = payload_q[i];
            phy_d[i]     = phy_q[i];
            loaded_d[i]  = wk_loaded[i];
            value_d[i]   = wk_value[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && i >= int'(sel_idx)) begin
                payload_d[i] = payload_q[i+1];
                phy_d[i]     = phy_q[i+1];
                loaded_d[i]  = wk_loaded[i+1];
                value_d[i]   = wk_value[i+1];
            end
        end
        base = int'(count_q) - (do_issue ? 1 : 0);
        pos  = 0;
        idx  = 0;
        nl   = '0;
        nv   = '0;
        if (accept) begin
            for (int k = 0; k < READREG_WIDTH; k++) begin
                if (iq.in_valid[k]) begin
                    idx = base + pos;
                    nl  = iq.in_src_loaded[k];
                    nv  = iq.in_src_value[k];
`ifdef ISSUE_QUEUE_INSERT_WAKEUP_EN
                    for (int s = 0; s < 2; s++) begin
                        if (!iq.in_src_loaded[k][s]) begin
                            for (int c = WAKEUP_NUM - 1; c >= 0; c--) begin
                                if (iq.wakeup_enable[c] &&
                                    iq.wakeup_phy_id[c] == iq.in_src_phy[k][s]) begin
                                    nl[s] = 1'b1;
                                    nv[s] = iq.wakeup_value[c];
                                end
                            end
                        end
                    end
`endif
                    if (idx < DEPTH) begin
                        payload_d[IW'(idx)] = iq.in_payload[k];
                        phy_d[IW'(idx)]     = iq.in_src_phy[k];
                        loaded_d[IW'(idx)]  = nl;
                        value_d[IW'(idx)]   = nv;
                    end
                    pos = pos + 1;
                end
            end
        end
        count_d = iq.flush ? '0 : CW'(base + pos);
    end

    // Occupancy register; flush and reset empty the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    // Entry storage; only meaningful below count_q, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            payload_q[i] <= payload_d[i];
            phy_q[i]     <= phy_d[i];
            loaded_q[i]  <= loaded_d[i];
            value_q[i]   <= value_d[i];
        end
    end
endmodule
